// File: rtl/dac_sample_pacer_if.sv
// dac_sample_pacer_if: producer-to-pacer sample stream, valid/ready handshake.
interface dac_sample_pacer_if;
    logic [11:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    modport master (output IN_DATA, IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, IN_VALID, output IN_READY);
endinterface

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: paces FIFO-buffered 12-bit samples to the MCP4921 serializer with a shaped LATCH pulse.
// Optional DAC_PACER_HOLD_LAST_EN: an underrun tick re-latches the last VALUE instead of skipping the pulse.
module dac_sample_pacer #(
    parameter int DEPTH      = 16,
    parameter int MIN_PERIOD = 800,
    parameter int LATCH_W    = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    dac_sample_pacer_if.slave     in_bus,
    input  logic                  ENABLE,
    input  logic [15:0]           PERIOD,
    input  logic                  CLR_UNDERRUN,
    output logic                  LATCH,
    output logic [11:0]           VALUE,
    output logic                  UNDERRUN,
    output logic [$clog2(DEPTH):0] LEVEL
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(LATCH_W) + 1;
    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);
    typedef enum logic [1:0] {IDLE, LOAD, PULSE} state_t;
    state_t        state;
    logic [11:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [15:0]   cnt, p_reg, p_next;
    logic [PW-1:0] pcnt;
    logic          full, empty, tick, push, pop, starve;
    // wrap bits differ with equal index bits: buffer is full
    assign full            = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty           = wr_ptr == rd_ptr;
    assign LEVEL           = wr_ptr - rd_ptr;
    assign in_bus.IN_READY = !full;
    assign push            = in_bus.IN_VALID && !full;
    assign p_next          = PERIOD < MIN_P ? MIN_P : PERIOD;
    assign tick            = ENABLE && cnt == p_reg - 16'd1;
    assign pop             = tick && state == IDLE && !empty;
    assign starve          = tick && state == IDLE && empty;
    always_ff @(posedge CLK)
        if (push) mem[wr_ptr[AW-1:0]] <= in_bus.IN_DATA;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            p_reg    <= MIN_P;
            UNDERRUN <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            cnt <= (!ENABLE || tick) ? '0 : cnt + 16'd1;
            if (!ENABLE || tick) p_reg <= p_next;
            UNDERRUN <= CLR_UNDERRUN ? 1'b0 : (starve ? 1'b1 : UNDERRUN);
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            VALUE <= '0;
            LATCH <= 1'b0;
            pcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        VALUE <= mem[rd_ptr[AW-1:0]];
                        state <= LOAD;
                    end
`ifdef DAC_PACER_HOLD_LAST_EN
                    else if (starve) state <= LOAD;
`else
`endif
                end
                LOAD: begin
                    LATCH <= 1'b1;
                    pcnt  <= '0;
                    state <= PULSE;
                end
                PULSE: begin
                    if (pcnt == PW'(LATCH_W - 1)) begin
                        LATCH <= 1'b0;
                        state <= IDLE;
                    end else pcnt <= pcnt + PW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: directed test-plan scenarios plus random traffic against a queue-based reference model.
module tb_dac_sample_pacer;
    localparam int DEPTH = 16, MIN_PERIOD = 800, LATCH_W = 4;
    logic        CLK = 0, RST_N = 0, ENABLE = 0, CLR_UNDERRUN = 0;
    logic [15:0] PERIOD = 16'd1000;
    logic        LATCH, UNDERRUN;
    logic [11:0] VALUE;
    logic [4:0]  LEVEL;
    int checks = 0, errors = 0;
    int cyc = 0, last_rise = 0, gap = 0;
    logic prev_latch = 0;
    int m_q[$];
    int m_cnt, m_p, m_val, m_age;
    bit m_under;
    dac_sample_pacer_if bus ();
    dac_sample_pacer #(.DEPTH(DEPTH), .MIN_PERIOD(MIN_PERIOD), .LATCH_W(LATCH_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_bus(bus), .ENABLE(ENABLE), .PERIOD(PERIOD),
        .CLR_UNDERRUN(CLR_UNDERRUN), .LATCH(LATCH), .VALUE(VALUE), .UNDERRUN(UNDERRUN), .LEVEL(LEVEL)
    );
    always #5 CLK = ~CLK;
    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask
    function automatic int clamp_p(input int p);
        return p < MIN_PERIOD ? MIN_PERIOD : p;
    endfunction
    task automatic model_reset();
        m_q.delete();
        m_cnt = 0; m_p = MIN_PERIOD; m_val = 0; m_age = 1000; m_under = 0;
    endtask
    // one clock of the reference: ticks every P enabled clocks, VALUE at t+1, LATCH t+2..t+1+LATCH_W
    task automatic model_step();
        bit tick, wr;
        int sz;
        if (!RST_N) begin model_reset(); return; end
        tick = ENABLE && m_cnt == m_p - 1;
        sz = m_q.size();
        wr = bus.IN_VALID && sz < DEPTH;
        if (m_age < 1000) m_age++;
        if (tick && sz > 0) begin m_val = m_q.pop_front(); m_age = 1; end
`ifdef DAC_PACER_HOLD_LAST_EN
        if (tick && sz == 0) m_age = 1;
`endif
        if (wr) m_q.push_back(int'(bus.IN_DATA));
        m_under = CLR_UNDERRUN ? 0 : ((tick && sz == 0) ? 1 : m_under);
        if (!ENABLE || tick) begin m_cnt = 0; m_p = clamp_p(int'(PERIOD)); end
        else m_cnt++;
    endtask
    task automatic step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        cyc++;
        if (LATCH && !prev_latch) begin gap = cyc - last_rise; last_rise = cyc; end
        prev_latch = LATCH;
        check("latch", LATCH, m_age >= 2 && m_age <= LATCH_W + 1);
        check("value", VALUE, m_val);
        check("level", LEVEL, m_q.size());
        check("ready", bus.IN_READY, m_q.size() < DEPTH);
        check("underrun", UNDERRUN, m_under);
    endtask
    task automatic push(input int d);
        bus.IN_VALID = 1; bus.IN_DATA = 12'(d);
        step();
        bus.IN_VALID = 0;
    endtask
    task automatic do_reset();
        RST_N = 0; ENABLE = 0; CLR_UNDERRUN = 0; bus.IN_VALID = 0;
        #1;
        model_reset();
        check("rst_latch", LATCH, 0);
        check("rst_value", VALUE, 0);
        check("rst_level", LEVEL, 0);
        check("rst_ready", bus.IN_READY, 1);
        check("rst_underrun", UNDERRUN, 0);
        step(); step();
        RST_N = 1;
    endtask
    initial begin
        int vprob;
        bus.IN_VALID = 0; bus.IN_DATA = '0;
        model_reset();
        @(negedge CLK);
        do_reset();
        PERIOD = 16'd1000;
        push('h123); push('hABC); step();
        ENABLE = 1;
        for (int n = 1; n <= 2010; n++) begin
            step();
            if (n == 1000) check("basic_v1", VALUE, 'h123);
            if (n >= 1001 && n <= 1004) check("basic_l1", LATCH, 1);
            if (n == 1005) check("basic_l1_end", LATCH, 0);
            if (n == 2000) check("basic_v2", VALUE, 'hABC);
            if (n == 2001) check("basic_l2", LATCH, 1);
        end
        do_reset();
        PERIOD = 16'd10;
        push('h001); push('h002); push('h003); step();
        ENABLE = 1;
        for (int n = 1; n <= 1610; n++) begin
            step();
            if (n == 1602) check("clamp_gap", gap, 800);
        end
        do_reset();
        PERIOD = 16'd800;
        for (int i = 0; i < 16; i++) push('h200 + i);
        check("full_ready", bus.IN_READY, 0);
        check("full_level", LEVEL, 16);
        bus.IN_VALID = 1; bus.IN_DATA = 12'h210;
        step();
        ENABLE = 1;
        for (int n = 1; n <= 803; n++) begin
            step();
            if (n == 799) check("full_hold", LEVEL, 16);
        end
        bus.IN_VALID = 0;
        check("full_refill", LEVEL, 16);
        do_reset();
        PERIOD = 16'd1000;
        push('h5A5); step();
        ENABLE = 1;
        for (int n = 1; n <= 2010; n++) begin
            step();
            if (n == 1999) check("under_pre", UNDERRUN, 0);
            if (n == 2000) check("under_set", UNDERRUN, 1);
`ifdef DAC_PACER_HOLD_LAST_EN
            if (n == 2001) check("under_relatch", LATCH, 1);
`else
            if (n == 2001) check("under_nolatch", LATCH, 0);
`endif
            if (n == 2001) check("under_value", VALUE, 'h5A5);
        end
        CLR_UNDERRUN = 1; step(); CLR_UNDERRUN = 0;
        check("under_clr", UNDERRUN, 0);
        do_reset();
        PERIOD = 16'd800;
        push('h311); push('h322); push('h333); step();
        ENABLE = 1;
        for (int n = 1; n <= 802; n++) step();
        check("midpulse_latch", LATCH, 1);
        do_reset();
        for (int n = 1; n <= 900; n++) step();
        push('h777); step();
        ENABLE = 1;
        for (int n = 1; n <= 805; n++) begin
            step();
            if (n == 799) check("post_rst_idle", VALUE, 0);
            if (n == 800) check("post_rst_value", VALUE, 'h777);
            if (n == 801) check("post_rst_latch", LATCH, 1);
        end
        do_reset();
        PERIOD = 16'd1000;
        push('h0AA); push('h0BB); push('h0CC); step();
        ENABLE = 1;
        for (int n = 1; n <= 2210; n++) begin
            if (n == 500) PERIOD = 16'd1200;
            step();
            if (n == 1002) check("pchg_rise1", last_rise - cyc + n, 1001);
            if (n == 2202) check("pchg_gap", gap, 1200);
        end
        do_reset();
        ENABLE = 1; vprob = 20;
        for (int n = 0; n < 12000; n++) begin
            if (n % 1000 == 0) vprob = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 90);
            bus.IN_VALID = $urandom_range(0, 99) < vprob;
            bus.IN_DATA = 12'($urandom);
            if ($urandom_range(0, 499) == 0) PERIOD = 16'($urandom_range(0, 1100));
            if ($urandom_range(0, 2999) == 0) ENABLE = ~ENABLE;
            CLR_UNDERRUN = $urandom_range(0, 199) == 0;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_sample_pacer.md
# dac_sample_pacer

- Paces 12-bit samples into the MCP4921 DAC serializer.
- Accepts samples from a producer over a valid/ready handshake and buffers them in a small FIFO.
- At a programmable sample period, presents one sample on `VALUE` and issues a `LATCH` pulse shaped for the serializer's two-flop edge detector.
- Enforces the serializer's minimum conversion time and flags FIFO underruns.

## Interface
- `DEPTH`, 16, FIFO depth in samples; power of two, 2..256.
- `MIN_PERIOD`, 800, minimum clocks between latches (covers the serializer's full frame plus CS/LDAC tail).
- `LATCH_W`, 4, `LATCH` high time in clocks; minimum 2.
- `CLK` input 1: single system clock, all logic on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `IN_DATA` input 12: sample from the producer.
- `IN_VALID` input 1: `IN_DATA` is valid.
- `IN_READY` output 1: FIFO can accept; a write occurs when `IN_VALID && IN_READY`.
- `ENABLE` input 1: runs the period counter; low means idle.
- `PERIOD` input 16: clocks per sample; values below `MIN_PERIOD` are treated as `MIN_PERIOD`.
- `CLR_UNDERRUN` input 1: clears `UNDERRUN` (level-sensitive, has priority over set).
- `LATCH` output 1: to serializer `LATCH`.
- `VALUE` output 12: to serializer `VALUE`; stable from 1 clock before `LATCH` rises until the next load.
- `UNDERRUN` output 1: sticky; a tick found the FIFO empty.
- `LEVEL` output log2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer, registered read/write pointers with wrap bit.
  - `IN_READY` = !full, computed from registered state.
  - Full FIFO: no write, even if a pop happens in the same cycle.
  - No fall-through: a sample written in cycle t can be popped at the earliest in t+1.
- **Period counter** `cnt`
  - While `ENABLE`=0: held at 0; `P` = max(`PERIOD`, `MIN_PERIOD`) is sampled every cycle.
  - While `ENABLE`=1: `cnt` counts 0..P-1; a tick occurs when `cnt`==P-1, then `cnt` wraps to 0.
  - `P` is resampled at each tick, so a `PERIOD` change takes effect on the next period.
- **FSM** (IDLE, LOAD, PULSE)
  - IDLE: on tick with FIFO non-empty, pop the head and go to LOAD.
  - IDLE: on tick with FIFO empty, set `UNDERRUN`; go to LOAD without a pop if `DAC_PACER_HOLD_LAST_EN`, otherwise stay in IDLE.
  - LOAD (1 clock): `VALUE` now holds the popped sample; go to PULSE.
  - PULSE: `LATCH`=1 for `LATCH_W` clocks, then back to IDLE.
- **ENABLE deassert mid-pulse:** the current LOAD/PULSE sequence completes; no further ticks.
- **Simultaneous events:**
  - Write and pop in the same cycle: `LEVEL` unchanged.
  - `CLR_UNDERRUN` and a set in the same cycle: `UNDERRUN` = 0.
- **Widths:** `cnt` is 16 bits; `LEVEL` saturates at `DEPTH` by construction and never wraps.

## Timing
- **Reset values:** `LATCH`=0, `VALUE`=0, `UNDERRUN`=0, `LEVEL`=0, `IN_READY`=1, FSM=IDLE, `cnt`=0, pointers=0.
- **Mid-operation reset:**
  - `LATCH` drops immediately and the FIFO is emptied.
  - The serializer may be left mid-frame; that is acceptable, since it finishes its own frame.
- **Latency:** tick in cycle t → `VALUE` updated at t+1 → `LATCH` high t+2..t+1+`LATCH_W`.
- **Serializer capture:** the serializer sees the `LATCH` edge at t+4 at the earliest, and `VALUE` is already stable by then.
- **Latch spacing:** consecutive `LATCH` rising edges are exactly P clocks apart.
- **Minimum period:** `MIN_PERIOD` ≥ `LATCH_W`+2 is guaranteed, so ticks never overlap a pulse.
- **Handshake:** throughput is one write per clock until full.

## Configuration
- **`DAC_PACER_HOLD_LAST_EN` defined:** an underrun tick still runs LOAD/PULSE and re-latches the unchanged `VALUE`. The DAC refresh cadence is constant.
- **Not defined:** an underrun tick produces no `LATCH` pulse. The DAC holds its output and the serializer stays idle.
- **Both cases:** `UNDERRUN` is set.

## Test plan
- **Basic pacing:** reset; `PERIOD`=1000; push 0x123, 0xABC; `ENABLE`=1 at cycle 0 → `VALUE`=0x123 at cycle 1000, `LATCH` high 1001..1004; `VALUE`=0xABC at 2000, `LATCH` 2001..2004.
- **Clamping:** `PERIOD`=10 → rising edges of `LATCH` are 800 clocks apart.
- **Full:** push 17 samples with `ENABLE`=0, `DEPTH`=16 → `IN_READY`=0 after the 16th write, `LEVEL`=16, and the 17th sample is held off until the first pop.
- **Underrun:** one sample, `PERIOD`=1000 → the second tick sets `UNDERRUN`. With the macro: a second `LATCH` pulse with `VALUE` still equal to the first sample. Without the macro: no second pulse. `CLR_UNDERRUN` then clears the flag.
- **Reset mid-pulse:** assert `RST_N`=0 during PULSE → `LATCH`=0, `LEVEL`=0, `VALUE`=0 asynchronously; after release, no pulse until a new sample plus P clocks of `ENABLE`.
- **Period change:** change `PERIOD` 1000→1200 mid-period → the current interval stays 1000 and the next is 1200.
